elastic: RTL and testbench

ELASTIC -- requirements
Module: elastic

---
 rtl/elastic.sv | 180 ++++++++++++++++++
 tb/tb_elastic.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic.sv
// -----------------------------------------------------------------------------
// elastic -- single-stage valid/ready pipeline buffer.
//
// Accepts words from an upstream valid/ready interface and presents them
// downstream one cycle later, in order, each exactly once. Holding a word
// keeps valid_o/data_o stable until the downstream side takes it.
//
// Build option (macro ELASTIC_SKID_EN):
//   undefined : one data register; ready_o = ~valid_o | ready_i, which is
//               combinational from ready_i.
//   defined   : main + skid register with an EMPTY/ONE/FULL state machine;
//               ready_o comes straight from a flop, so there is no
//               combinational path from ready_i or valid_i to ready_o.
//
// Parameters:
//   width_p          data path width in bits
//   datapath_reset_p 1: data registers clear on reset; 0: they keep contents
//
// Ports:
//   clk_i    in   clock, all state updates on the rising edge
//   reset_i  in   synchronous, active-high reset
//   data_i   in   upstream data          (width_p)
//   valid_i  in   upstream data valid
//   ready_o  out  block accepts data this cycle
//   valid_o  out  downstream data valid
//   data_o   out  downstream data        (width_p)
//   ready_i  in   downstream accepts data this cycle
// -----------------------------------------------------------------------------
module elastic #(
    parameter int width_p          = 8,
    parameter bit datapath_reset_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

`ifdef ELASTIC_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ready;
    logic               r_valid;
    logic [width_p-1:0] r_main;
    logic [width_p-1:0] r_skid;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_in_xfer  = valid_i & r_ready;
    assign w_out_xfer = r_valid & ready_i;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && !w_out_xfer) begin
                    // Head word stays put; the newcomer waits in skid.
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (!w_in_xfer && w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end else if (w_in_xfer && w_out_xfer) begin
                    // Pass-through: new word replaces the departing one.
                    w_load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // ready/valid are registered copies of the next state's decode, so the
    // outputs leave a flop directly.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != FULL);
            r_valid <= (w_state_nxt != EMPTY);
        end
    end

    // NOTE: data registers need no reset for correctness (valid qualifies
    // them); clearing them is optional and controlled by datapath_reset_p.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (datapath_reset_p) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            if (w_load_main_in) begin
                r_main <= data_i;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= data_i;
            end
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_main;

`else

    logic               r_valid;
    logic [width_p-1:0] r_data;
    logic               w_ready;
    logic               w_in_xfer;

    // Space exists when empty, or when the held word leaves this cycle.
    assign w_ready   = ~r_valid | ready_i;
    assign w_in_xfer = valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (datapath_reset_p) begin
                r_data <= '0;
            end
        end else if (w_in_xfer) begin
            r_data <= data_i;
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data;

`endif

endmodule

// File: tb/tb_elastic.sv
// -----------------------------------------------------------------------------
// tb_elastic -- self-checking bench for elastic.
//
// Two instances share all inputs: u_dut0 keeps data on reset
// (datapath_reset_p=0), u_dut1 clears it (datapath_reset_p=1). Both are
// compared every cycle against a queue-based model: the block is a FIFO of
// capacity 1 (plain build) or 2 (ELASTIC_SKID_EN) whose head is shown on
// data_o; when empty, data_o shows the last word shown (or 0 after a
// clearing reset).
// -----------------------------------------------------------------------------
module tb_elastic;

    localparam int W = 16;

`ifdef ELASTIC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;

    logic         ready_o0, valid_o0, ready_o1, valid_o1;
    logic [W-1:0] data_o0, data_o1;

    always #5 clk_i = ~clk_i;

    elastic #(.width_p(W), .datapath_reset_p(1'b0)) u_dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o0), .valid_o(valid_o0), .data_o(data_o0), .ready_i(ready_i)
    );

    elastic #(.width_p(W), .datapath_reset_p(1'b1)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o1), .valid_o(valid_o1), .data_o(data_o1), .ready_i(ready_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_shown0, m_shown1;
    bit           m_known0, m_known1;
    bit           m_in, m_out, m_rst;
    logic [W-1:0] m_din;
    int           n_in  = 0;
    int           n_out = 0;
    int           cap;

    function automatic bit model_ready(input bit r);
        if (SKID) return (m_q.size() < cap);
        return (m_q.size() == 0) || r;
    endfunction

    // Drive one cycle's inputs and compare both DUTs against the model.
    task automatic apply(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
        bit ev, er;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        reset_i = rst;
        #2;
        ev = (m_q.size() > 0);
        er = model_ready(r);
        check("valid_o0", valid_o0, ev);
        check("valid_o1", valid_o1, ev);
        check("ready_o0", ready_o0, er);
        check("ready_o1", ready_o1, er);
        if (ev) begin
            m_shown0 = m_q[0];
            m_shown1 = m_q[0];
            m_known0 = 1'b1;
            m_known1 = 1'b1;
        end
        if (m_known0) check("data_o0", data_o0, m_shown0);
        if (m_known1) check("data_o1", data_o1, m_shown1);
        m_in  = v && er;
        m_out = ev && r;
        m_rst = rst;
        m_din = d;
    endtask

    // Clock edge plus the model's view of what happened on it.
    task automatic advance();
        @(posedge clk_i);
        if (m_rst) begin
            m_q.delete();
            m_shown1 = '0;
            m_known1 = 1'b1;
        end else begin
            if (m_out) begin
                void'(m_q.pop_front());
                n_out++;
            end
            if (m_in) begin
                m_q.push_back(m_din);
                n_in++;
            end
        end
        #1;
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic rst);
        apply(v, d, r, rst);
        advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         ev;
        logic [W-1:0] ed;
        logic         er;
        logic         cd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int budget;
        int out_before;
        logic hold_r;

        cap = SKID ? 2 : 1;

        // Basic latency, then backpressure with 0x11/0x22/0x33. The source
        // holds a word until it is accepted.
        tbl.push_back('{1'b1, 16'h00A5, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00A5, 1'b1, 1'b1});
`ifdef ELASTIC_SKID_EN
        tbl.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 16'h00A5, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h0033, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0033, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0033, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0033, 1'b1, 1'b1, 16'h0022, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0033, 1'b1, 1'b1});
`else
        tbl.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 16'h00A5, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0022, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h0033, 1'b1, 1'b1, 16'h0022, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0033, 1'b1, 1'b1});
`endif

        // Initial reset: outputs are undefined until it has been applied.
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        m_shown1 = '0;
        m_known1 = 1'b1;
        m_known0 = 1'b0;

        // Reset state.
        reset_i = 1'b0;
        #2;
        check("reset_valid_o", valid_o0, 1'b0);
        check("reset_ready_o", ready_o0, 1'b1);
        check("reset_data_o1", data_o1, 16'h0000);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d_valid", i), valid_o0, tbl[i].ev);
            check($sformatf("tbl%0d_ready", i), ready_o0, tbl[i].er);
            if (tbl[i].cd) begin
                check($sformatf("tbl%0d_data0", i), data_o0, tbl[i].ed);
                check($sformatf("tbl%0d_data1", i), data_o1, tbl[i].ed);
            end
            advance();
        end

        // Streaming 0x01..0x10: one word per cycle, no bubbles after the first.
        out_before = n_out;
        for (int k = 1; k <= 16; k++) begin
            apply(1'b1, W'(k), 1'b1, 1'b0);
            if (k > 1) begin
                check("stream_valid", valid_o0, 1'b1);
                check("stream_data", data_o0, W'(k - 1));
            end
            advance();
        end
        cycle(1'b0, 16'hDEAD, 1'b1, 1'b0);
        cycle(1'b0, 16'hBEEF, 1'b1, 1'b0);
        check("stream_count", n_out - out_before, 16);

        // Ready path: with the state fixed, toggling ready_i must not move
        // ready_o in the skid build, and must move it in the plain build.
        cycle(1'b1, 16'h0101, 1'b0, 1'b0);
        cycle(1'b1, 16'h0202, 1'b0, 1'b0);
        apply(1'b1, 16'h0303, 1'b0, 1'b0);
        hold_r = ready_o0;
        ready_i = 1'b1;
        #1;
`ifdef ELASTIC_SKID_EN
        check("ready_no_comb_path", ready_o0, hold_r);
        valid_i = 1'b0;
        #1;
        check("ready_no_comb_valid", ready_o0, hold_r);
        valid_i = 1'b1;
`else
        check("ready_follows_ready_i", ready_o0, 1'b1);
`endif
        ready_i = 1'b0;
        #1;
        check("ready_restored", ready_o0, hold_r);
        advance();

        // Reset while holding data (FULL in the skid build), with a transfer
        // offered on that very edge: all words must be discarded.
        apply(1'b1, 16'h0404, 1'b1, 1'b1);
        advance();
        apply(1'b0, 16'h0000, 1'b0, 1'b0);
        check("rst_full_valid", valid_o0, 1'b0);
        check("rst_full_ready", ready_o0, 1'b1);
        check("rst_full_data1", data_o1, 16'h0000);
        check("rst_full_data0_held", data_o0, 16'h0101);
        advance();
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic, 1000 words, 50% valid / 50% ready.
        n_in  = 0;
        n_out = 0;
        budget = 0;
        while (n_in < 1000 && budget < 20000) begin
            cycle(1'($urandom % 2), W'($urandom), 1'($urandom % 2), 1'b0);
            budget++;
        end
        check("random_words_accepted", n_in, 1000);
        budget = 0;
        while (m_q.size() > 0 && budget < 100) begin
            cycle(1'b0, W'($urandom), 1'($urandom % 2), 1'b0);
            budget++;
        end
        check("random_drained", m_q.size(), 0);
        check("random_words_out", n_out, n_in);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
